// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and constants for the register-file write-side blocks.
//   REG_ADDR_W / DATA_W : register address and data widths
//   NUM_REGS            : architectural register count
//   REG_ZERO            : hard-wired zero register; writes to it are discarded
//   wb_src_e            : which source drives the RF write port in a given cycle
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_LATE,
    SRC_SKID
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: pending-destination scoreboard for long-latency writes.
//   clk, reset (async, active-low)
//   issue_valid/issue_addr/issue_ready : reserve a destination register
//   clr_valid/clr_addr                 : the late write for clr_addr reached the RF port
//   rd_addr1/rd_addr2 -> hazard1/hazard2 : source register still awaits a late write
//   busy    : at least one reservation outstanding
//   pending : raw pending vector, one bit per register
module wb_scoreboard
  import regfile_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  reg_addr_t           issue_addr,
  output logic                issue_ready,
  input  logic                clr_valid,
  input  reg_addr_t           clr_addr,
  input  reg_addr_t           rd_addr1,
  input  reg_addr_t           rd_addr2,
  output logic                hazard1,
  output logic                hazard2,
  output logic                busy,
  output logic [NUM_REGS-1:0] pending
);

  localparam int                CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0]    count;
  logic [NUM_REGS-1:0] pending_d;
  logic                set_en;
  logic                clr_en;

  // A register already pending cannot be re-reserved; this also blocks an
  // issue that coincides with the clear of the same register.
  assign issue_ready = (count < MAX_CNT) && !pending[issue_addr];
  assign set_en      = issue_valid && issue_ready && (issue_addr != REG_ZERO);
  // Clearing a register that was never reserved changes nothing.
  assign clr_en      = clr_valid && (clr_addr != REG_ZERO) && pending[clr_addr];

  assign hazard1 = (rd_addr1 != REG_ZERO) && pending[rd_addr1];
  assign hazard2 = (rd_addr2 != REG_ZERO) && pending[rd_addr2];
  assign busy    = (count != '0);

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pending_d = pending;
    if (clr_en) pending_d[clr_addr]   = 1'b0;
    if (set_en) pending_d[issue_addr] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pending_d;
      // Simultaneous set and clear (different registers) leaves count as is.
      unique case ({set_en, clr_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges the single-cycle pipeline writeback and a
// multi-cycle (divider/load) result stream onto the one register-file write
// port, and tracks pending late destinations for decode hazard detection.
//   clk, reset (async, active-low)
//   pipe_wr/pipe_addr/pipe_data           : pipeline writeback, absolute priority
//   issue_valid/issue_addr/issue_ready    : reserve a late destination
//   late_valid/late_ready/late_addr/late_data : late result handshake
//   rd_addr1/rd_addr2 -> hazard1/hazard2  : decode source-register stall
//   rf_wr/rf_addr/rf_data                 : registered RF write port
//   busy                                  : any reservation outstanding
// Build option: define REGFILE_WB_SKID_EN to add a one-entry skid register
// so late_ready is registered and late results are accepted even while the
// pipeline owns the write port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      pipe_wr,
  input  reg_addr_t pipe_addr,
  input  reg_data_t pipe_data,
  input  logic      issue_valid,
  input  reg_addr_t issue_addr,
  output logic      issue_ready,
  input  logic      late_valid,
  output logic      late_ready,
  input  reg_addr_t late_addr,
  input  reg_data_t late_data,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output logic      hazard1,
  output logic      hazard2,
  output logic      rf_wr,
  output reg_addr_t rf_addr,
  output reg_data_t rf_data,
  output logic      busy
);

  logic                eff_pipe;
  logic                late_fire;
  logic                late_take;
  wb_src_e             src;
  reg_addr_t           wr_addr;
  reg_data_t           wr_data;
  logic                clr_valid;
  reg_addr_t           clr_addr;
  logic [NUM_REGS-1:0] pending;

  assign eff_pipe  = pipe_wr && (pipe_addr != REG_ZERO);
  assign late_fire = late_valid && late_ready;
  // A late result to $0 completes the handshake but is dropped.
  assign late_take = late_fire && (late_addr != REG_ZERO);

`ifdef REGFILE_WB_SKID_EN
  logic      skid_valid;
  reg_addr_t skid_addr;
  reg_data_t skid_data;

  assign late_ready = !skid_valid;

  always_comb begin
    src = SRC_NONE;
    if (eff_pipe)        src = SRC_PIPE;
    else if (skid_valid) src = SRC_SKID;
    else if (late_take)  src = SRC_LATE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) skid_valid <= 1'b0;
    else if (eff_pipe && late_take) skid_valid <= 1'b1;
    else if (src == SRC_SKID)       skid_valid <= 1'b0;
  end

  // NOTE: payload registers qualified by a valid bit need no reset; only the
  // valid bit must come out of reset in a known state.
  always_ff @(posedge clk) begin
    if (eff_pipe && late_take) begin
      skid_addr <= late_addr;
      skid_data <= late_data;
    end
  end
`else
  assign late_ready = !eff_pipe;

  always_comb begin
    src = SRC_NONE;
    if (eff_pipe)       src = SRC_PIPE;
    else if (late_take) src = SRC_LATE;
  end
`endif

  always_comb begin
    wr_addr   = pipe_addr;
    wr_data   = pipe_data;
    clr_valid = 1'b0;
    clr_addr  = late_addr;
    unique case (src)
      SRC_LATE: begin
        wr_addr   = late_addr;
        wr_data   = late_data;
        clr_valid = 1'b1;
      end
`ifdef REGFILE_WB_SKID_EN
      SRC_SKID: begin
        wr_addr   = skid_addr;
        wr_data   = skid_data;
        clr_valid = 1'b1;
        clr_addr  = skid_addr;
      end
`endif
      default: ;
    endcase
  end

  // Registered write port; address/data hold when no write is selected.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_wr   <= 1'b0;
      rf_addr <= REG_ZERO;
      rf_data <= '0;
    end else begin
      rf_wr <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        rf_addr <= wr_addr;
        rf_data <= wr_data;
      end
    end
  end

  wb_scoreboard #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .issue_ready(issue_ready),
    .clr_valid  (clr_valid),
    .clr_addr   (clr_addr),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .busy       (busy),
    .pending    (pending)
  );

  // Protocol misuse: hardware still writes, the clear is simply a no-op.
  a_late_reserved: assert property (@(posedge clk) disable iff (!reset)
    late_take |-> pending[late_addr])
    else $error("late result to unreserved register %0d", late_addr);

  a_pipe_not_pending: assert property (@(posedge clk) disable iff (!reset)
    eff_pipe |-> !pending[pipe_addr])
    else $error("pipeline write to pending register %0d", pipe_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      reset;
  logic      pipe_wr;
  reg_addr_t pipe_addr;
  reg_data_t pipe_data;
  logic      issue_valid;
  reg_addr_t issue_addr;
  logic      issue_ready;
  logic      late_valid;
  logic      late_ready;
  reg_addr_t late_addr;
  reg_data_t late_data;
  reg_addr_t rd_addr1;
  reg_addr_t rd_addr2;
  logic      hazard1;
  logic      hazard2;
  logic      rf_wr;
  reg_addr_t rf_addr;
  reg_data_t rf_data;
  logic      busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_OUTSTANDING(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_wr    (pipe_wr),
    .pipe_addr  (pipe_addr),
    .pipe_data  (pipe_data),
    .issue_valid(issue_valid),
    .issue_addr (issue_addr),
    .issue_ready(issue_ready),
    .late_valid (late_valid),
    .late_ready (late_ready),
    .late_addr  (late_addr),
    .late_data  (late_data),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .hazard1    (hazard1),
    .hazard2    (hazard2),
    .rf_wr      (rf_wr),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .busy       (busy)
  );

  // Advance to just after the next rising edge; inputs change and registered
  // outputs are sampled here, 1 time unit clear of the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wr     = 1'b0;
    pipe_addr   = '0;
    pipe_data   = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    late_valid  = 1'b0;
    late_addr   = '0;
    late_data   = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    reset    = 1'b0;
    step();
    step();
    tests_run++; if (rf_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_wr: got %0b want 0", rf_wr); end
    tests_run++; if (rf_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_rf_addr: got %0d want 0", rf_addr); end
    tests_run++; if (rf_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rf_data: got %h want 0", rf_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_issue_ready: got %0b want 1", issue_ready); end
    tests_run++; if (late_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_late_ready: got %0b want 1", late_ready); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_pipe_write();
    pipe_wr = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h0000_00AA;
    #1;
    tests_run++; if (late_ready !== 1'b0) begin tests_failed++; $display("FAIL pipe8_late_ready: got %0b want 0", late_ready); end
    step();
    tests_run++; if ({rf_wr, rf_addr, rf_data} !== {1'b1, 5'd8, 32'h0000_00AA}) begin tests_failed++; $display("FAIL pipe8_rf: got wr=%0b addr=%0d data=%h want wr=1 addr=8 data=000000aa", rf_wr, rf_addr, rf_data); end
    pipe_addr = 5'd0; pipe_data = 32'h0000_0055;
    #1;
    tests_run++; if (late_ready !== 1'b1) begin tests_failed++; $display("FAIL pipe0_late_ready: got %0b want 1", late_ready); end
    step();
    tests_run++; if ({rf_wr, rf_addr, rf_data} !== {1'b0, 5'd8, 32'h0000_00AA}) begin tests_failed++; $display("FAIL pipe0_rf_hold: got wr=%0b addr=%0d data=%h want wr=0 addr=8 data=000000aa", rf_wr, rf_addr, rf_data); end
    idle_inputs();
  endtask

  task automatic test_late_write();
    issue_valid = 1'b1; issue_addr = 5'd9;
    #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL issue9_ready: got %0b want 1", issue_ready); end
    step();
    issue_valid = 1'b0;
    rd_addr1 = 5'd9;
    #1;
    tests_run++; if (hazard1 !== 1'b1) begin tests_failed++; $display("FAIL issue9_hazard1: got %0b want 1", hazard1); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL issue9_busy: got %0b want 1", busy); end
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL issue9_reissue_ready: got %0b want 0", issue_ready); end
    late_valid = 1'b1; late_addr = 5'd9; late_data = 32'h0000_BEEF;
    #1;
    tests_run++; if (late_ready !== 1'b1) begin tests_failed++; $display("FAIL late9_ready: got %0b want 1", late_ready); end
    tests_run++; if (hazard1 !== 1'b1) begin tests_failed++; $display("FAIL late9_hazard_same_cycle: got %0b want 1", hazard1); end
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if (hazard1 !== 1'b0) begin tests_failed++; $display("FAIL late9_hazard_after: got %0b want 0", hazard1); end
    tests_run++; if ({rf_wr, rf_addr, rf_data} !== {1'b1, 5'd9, 32'h0000_BEEF}) begin tests_failed++; $display("FAIL late9_rf: got wr=%0b addr=%0d data=%h want wr=1 addr=9 data=0000beef", rf_wr, rf_addr, rf_data); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL late9_busy: got %0b want 0", busy); end
    idle_inputs();
    rd_addr1 = 5'd0;
    step();
  endtask

  task automatic test_collision();
    issue_valid = 1'b1; issue_addr = 5'd4;
    step();
    issue_valid = 1'b0;
    rd_addr2 = 5'd4;
    pipe_wr = 1'b1; pipe_addr = 5'd3; pipe_data = 32'h0000_0033;
    late_valid = 1'b1; late_addr = 5'd4; late_data = 32'h0000_0044;
    #1;
    tests_run++; if (late_ready !== 1'b0) begin tests_failed++; $display("FAIL coll_late_ready: got %0b want 0", late_ready); end
    step();
    pipe_wr = 1'b0;
    #1;
    tests_run++; if ({rf_wr, rf_addr, rf_data} !== {1'b1, 5'd3, 32'h0000_0033}) begin tests_failed++; $display("FAIL coll_rf_pipe: got wr=%0b addr=%0d data=%h want wr=1 addr=3 data=00000033", rf_wr, rf_addr, rf_data); end
    tests_run++; if (hazard2 !== 1'b1) begin tests_failed++; $display("FAIL coll_hazard2_held: got %0b want 1", hazard2); end
    tests_run++; if (late_ready !== 1'b1) begin tests_failed++; $display("FAIL coll_late_ready_idle: got %0b want 1", late_ready); end
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if ({rf_wr, rf_addr, rf_data} !== {1'b1, 5'd4, 32'h0000_0044}) begin tests_failed++; $display("FAIL coll_rf_late: got wr=%0b addr=%0d data=%h want wr=1 addr=4 data=00000044", rf_wr, rf_addr, rf_data); end
    tests_run++; if (hazard2 !== 1'b0) begin tests_failed++; $display("FAIL coll_hazard2_clear: got %0b want 0", hazard2); end
    idle_inputs();
    rd_addr2 = 5'd0;
    step();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      issue_valid = 1'b1; issue_addr = reg_addr_t'(i);
      step();
    end
    issue_valid = 1'b0; issue_addr = 5'd5;
    rd_addr1 = 5'd4;
    #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL fill_issue_ready: got %0b want 0", issue_ready); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL fill_busy: got %0b want 1", busy); end
    tests_run++; if (hazard1 !== 1'b1) begin tests_failed++; $display("FAIL fill_hazard4: got %0b want 1", hazard1); end
    late_valid = 1'b1; late_addr = 5'd2; late_data = 32'h0000_0022;
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL fill_issue_ready_after: got %0b want 1", issue_ready); end
    tests_run++; if (rf_addr !== 5'd2) begin tests_failed++; $display("FAIL fill_rf_addr: got %0d want 2", rf_addr); end
    late_valid = 1'b1; late_addr = 5'd1; step();
    late_addr = 5'd3; step();
    late_addr = 5'd4; step();
    late_valid = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL fill_drained_busy: got %0b want 0", busy); end
    tests_run++; if (hazard1 !== 1'b0) begin tests_failed++; $display("FAIL fill_drained_hazard4: got %0b want 0", hazard1); end
    idle_inputs();
    rd_addr1 = 5'd0;
  endtask

  task automatic test_same_cycle();
    // Issue and clear of the same register: reissue is refused.
    issue_valid = 1'b1; issue_addr = 5'd6;
    step();
    late_valid = 1'b1; late_addr = 5'd6; late_data = 32'h0000_0066;
    rd_addr1 = 5'd6;
    #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL same_addr_issue_ready: got %0b want 0", issue_ready); end
    step();
    issue_valid = 1'b0; late_valid = 1'b0;
    #1;
    tests_run++; if ({hazard1, busy} !== 2'b00) begin tests_failed++; $display("FAIL same_addr_after: got hazard1=%0b busy=%0b want 0 0", hazard1, busy); end
    // Issue of one register while another clears: count stays at one.
    issue_valid = 1'b1; issue_addr = 5'd10;
    step();
    issue_addr = 5'd11;
    late_valid = 1'b1; late_addr = 5'd10;
    rd_addr1 = 5'd10; rd_addr2 = 5'd11;
    step();
    issue_valid = 1'b0; late_valid = 1'b0;
    #1;
    tests_run++; if ({hazard1, hazard2, busy} !== 3'b011) begin tests_failed++; $display("FAIL diff_addr_state: got h1=%0b h2=%0b busy=%0b want 0 1 1", hazard1, hazard2, busy); end
    late_valid = 1'b1; late_addr = 5'd11;
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL diff_addr_count: got busy=%0b want 0", busy); end
    idle_inputs();
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
  endtask

  task automatic test_double_issue_and_zero();
    issue_valid = 1'b1; issue_addr = 5'd7;
    step();
    #1;
    tests_run++; if (issue_ready !== 1'b0) begin tests_failed++; $display("FAIL issue7_second_ready: got %0b want 0", issue_ready); end
    step();
    issue_valid = 1'b0;
    late_valid = 1'b1; late_addr = 5'd7; late_data = 32'h0000_0077;
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL issue7_single_count: got busy=%0b want 0", busy); end
    // Issue to $0: accepted, no reservation.
    issue_valid = 1'b1; issue_addr = 5'd0;
    #1;
    tests_run++; if (issue_ready !== 1'b1) begin tests_failed++; $display("FAIL issue0_ready: got %0b want 1", issue_ready); end
    step();
    issue_valid = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL issue0_busy: got %0b want 0", busy); end
    // Late result to $0: consumed, never writes.
    late_valid = 1'b1; late_addr = 5'd0; late_data = 32'hDEAD_0000;
    #1;
    tests_run++; if (late_ready !== 1'b1) begin tests_failed++; $display("FAIL late0_ready: got %0b want 1", late_ready); end
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if ({rf_wr, rf_addr} !== {1'b0, 5'd7}) begin tests_failed++; $display("FAIL late0_dropped: got wr=%0b addr=%0d want wr=0 addr=7", rf_wr, rf_addr); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    issue_valid = 1'b1; issue_addr = 5'd12;
    step();
    issue_valid = 1'b0;
    late_valid = 1'b1; late_addr = 5'd12; late_data = 32'h1200_0012;
    for (int i = 0; i < 3; i++) begin
      pipe_wr = 1'b1; pipe_addr = reg_addr_t'(13 + i); pipe_data = 32'hC0 + i;
      #1;
      tests_run++; if (late_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_late_ready_%0d: got %0b want 0", i, late_ready); end
      step();
      tests_run++; if ({rf_wr, rf_addr} !== {1'b1, reg_addr_t'(13 + i)}) begin tests_failed++; $display("FAIL b2b_pipe_%0d: got wr=%0b addr=%0d want wr=1 addr=%0d", i, rf_wr, rf_addr, 13 + i); end
    end
    pipe_wr = 1'b0;
    #1;
    tests_run++; if (late_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_late_ready_idle: got %0b want 1", late_ready); end
    step();
    late_valid = 1'b0;
    #1;
    tests_run++; if ({rf_wr, rf_addr, rf_data, busy} !== {1'b1, 5'd12, 32'h1200_0012, 1'b0}) begin tests_failed++; $display("FAIL b2b_late_drain: got wr=%0b addr=%0d data=%h busy=%0b want 1 12 12000012 0", rf_wr, rf_addr, rf_data, busy); end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_addr = 5'd20;
    step();
    issue_valid = 1'b0;
    rd_addr1 = 5'd20;
    pipe_wr = 1'b1; pipe_addr = 5'd5; pipe_data = 32'h0000_1234;
    step();
    reset = 1'b0;
    #1;
    tests_run++; if ({rf_wr, busy, hazard1, hazard2} !== 4'b0000) begin tests_failed++; $display("FAIL reset_mid: got wr=%0b busy=%0b h1=%0b h2=%0b want all 0", rf_wr, busy, hazard1, hazard2); end
    step();
    idle_inputs();
    #1;
    reset = 1'b1;
    step();
    tests_run++; if ({rf_wr, rf_addr, rf_data} !== {1'b0, 5'd0, 32'h0}) begin tests_failed++; $display("FAIL reset_mid_after: got wr=%0b addr=%0d data=%h want 0 0 0", rf_wr, rf_addr, rf_data); end
    rd_addr1 = 5'd0;
  endtask

  initial begin
    test_reset();
    test_pipe_write();
    test_late_write();
    test_collision();
    test_fill();
    test_same_cycle();
    test_double_issue_and_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
